// File: rtl/alu_input_seq_pkg.sv
// rtl/alu_input_seq_pkg.sv - shared types and key index constants for the ALU input sequencer
package alu_input_seq_pkg;

    typedef logic [3:0] aluop_t;

    typedef enum logic {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } seq_state_t;

    localparam int KEY_LOAD_A  = 0;
    localparam int KEY_LOAD_B  = 1;
    localparam int KEY_LOAD_OP = 2;
    localparam int KEY_EXEC    = 3;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchronizer plus counter debouncer for one active-low pushbutton
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic raw_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_n;
    logic          sync2_n;
    logic          stable_n;
    logic [CW-1:0] cnt;

    // press_pulse is registered together with the stable flip, so it appears
    // in the same cycle the debounced level changes.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sync1_n     <= 1'b1;
            sync2_n     <= 1'b1;
            stable_n    <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1_n     <= raw_n;
            sync2_n     <= sync1_n;
            press_pulse <= 1'b0;
            if (sync2_n == stable_n) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_n    <= sync2_n;
                cnt         <= '0;
                press_pulse <= ~sync2_n;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pressed = ~stable_n;

endmodule

// File: rtl/alu_input_seq.sv
// rtl/alu_input_seq.sv - key/switch input sequencer issuing ALU requests; SIGN_EXT_EN selects sign-extended operands
module alu_input_seq
    import alu_input_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DW              = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [3:0]    key_n,
    input  logic [17:0]   sw,
    output logic [DW-1:0] port_a,
    output logic [DW-1:0] port_b,
    output logic [3:0]    aluop,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [2:0]    loaded,
    output logic          err
);

    logic [17:0]   sw_meta;
    logic [17:0]   sw_sync;
    logic [3:0]    ev;
    logic [3:0]    key_pressed;
    logic [DW-1:0] sw_ext;
    logic          unused_bits;

    seq_state_t    state, state_nxt;
    logic [DW-1:0] a_nxt, b_nxt;
    aluop_t        op_nxt;
    logic [2:0]    loaded_nxt;
    logic          valid_nxt;
    logic          err_nxt;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .CLK        (CLK),
            .nRST       (nRST),
            .raw_n      (key_n[k]),
            .pressed    (key_pressed[k]),
            .press_pulse(ev[k])
        );
    end

    // Switches are quasi-static: synchronized only, never debounced.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign unused_bits = &{1'b0, sw_sync[17:16], key_pressed};

`ifdef SIGN_EXT_EN
    assign sw_ext = {{(DW-16){sw_sync[15]}}, sw_sync[15:0]};
`else
    assign sw_ext = {{(DW-16){1'b0}}, sw_sync[15:0]};
`endif

    always_comb begin
        state_nxt  = state;
        a_nxt      = port_a;
        b_nxt      = port_b;
        op_nxt     = aluop_t'(aluop);
        loaded_nxt = loaded;
        valid_nxt  = req_valid;
        err_nxt    = 1'b0;
        case (state)
            COLLECT: begin
                if (ev[KEY_LOAD_A]) begin
                    a_nxt         = sw_ext;
                    loaded_nxt[0] = 1'b1;
                end
                if (ev[KEY_LOAD_B]) begin
                    b_nxt         = sw_ext;
                    loaded_nxt[1] = 1'b1;
                end
                if (ev[KEY_LOAD_OP]) begin
                    op_nxt        = aluop_t'(sw_sync[3:0]);
                    loaded_nxt[2] = 1'b1;
                end
                // Execute only counts against flags as they stood before this cycle.
                if (ev[KEY_EXEC]) begin
                    if (loaded == 3'b111 && ev[2:0] == 3'b000) begin
                        valid_nxt = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (req_valid && req_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= COLLECT;
            port_a    <= '0;
            port_b    <= '0;
            aluop     <= '0;
            loaded    <= '0;
            req_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            port_a    <= a_nxt;
            port_b    <= b_nxt;
            aluop     <= op_nxt;
            loaded    <= loaded_nxt;
            req_valid <= valid_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_input_seq.sv
// tb/tb_alu_input_seq.sv - directed self-checking bench for alu_input_seq with DEBOUNCE_CYCLES=4
module tb_alu_input_seq;

    logic        CLK;
    logic        nRST;
    logic [3:0]  key_n;
    logic [17:0] sw;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [3:0]  aluop;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  loaded;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SIGN_EXT_EN
    localparam logic [31:0] EXT_8001 = 32'hFFFF8001;
`else
    localparam logic [31:0] EXT_8001 = 32'h00008001;
`endif

    alu_input_seq #(
        .DEBOUNCE_CYCLES(4),
        .DW             (32)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .key_n    (key_n),
        .sw       (sw),
        .port_a   (port_a),
        .port_b   (port_b),
        .aluop    (aluop),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .loaded   (loaded),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press_key(input int k);
        key_n[k] = 1'b0;
        tick(8);
        key_n[k] = 1'b1;
        tick(8);
    endtask

    task automatic do_reset(input int n);
        nRST = 1'b0;
        tick(n);
        nRST = 1'b1;
    endtask

    initial begin
        nRST      = 1'b0;
        key_n     = 4'h0;
        sw        = 18'h0;
        req_ready = 1'b0;

        // 1: reset state and quiet period
        tick(2);
        nRST  = 1'b1;
        key_n = 4'hF;
        chk("rst_port_a", port_a, 32'h0);
        chk("rst_port_b", port_b, 32'h0);
        chk("rst_aluop", {28'h0, aluop}, 32'h0);
        chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("rst_loaded", {29'h0, loaded}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("quiet_loaded", {29'h0, loaded}, 32'h0);
            chk("quiet_err", {31'h0, err}, 32'h0);
        end

        // 2: glitch rejected, long hold loads once with 7-cycle latency
        sw = 18'h00005;
        tick(3);
        key_n[0] = 1'b0;
        tick(3);
        key_n[0] = 1'b1;
        tick(10);
        chk("glitch_port_a", port_a, 32'h0);
        chk("glitch_loaded", {29'h0, loaded}, 32'h0);
        key_n[0] = 1'b0;
        tick(6);
        chk("lat6_loaded", {29'h0, loaded}, 32'h0);
        tick(1);
        chk("lat7_loaded", {29'h0, loaded}, 32'h1);
        chk("lat7_port_a", port_a, 32'h5);
        sw = 18'h00007;
        tick(13);
        chk("hold_single_load", port_a, 32'h5);
        key_n[0] = 1'b1;
        tick(8);
        chk("release_no_load", port_a, 32'h5);

        // 3: full operation, stall, ignored keys, handshake, re-issue
        sw = 18'h00003;
        tick(3);
        press_key(1);
        chk("load_b", port_b, 32'h3);
        chk("loaded_ab", {29'h0, loaded}, 32'h3);
        sw = 18'h00002;
        tick(3);
        press_key(2);
        chk("load_op", {28'h0, aluop}, 32'h2);
        chk("loaded_all", {29'h0, loaded}, 32'h7);
        press_key(3);
        chk("issue_valid", {31'h0, req_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_valid", {31'h0, req_valid}, 32'h1);
            chk("stall_port_a", port_a, 32'h5);
        end
        sw = 18'h00009;
        tick(3);
        press_key(0);
        chk("issue_ignore_a", port_a, 32'h5);
        chk("issue_no_err", {31'h0, err}, 32'h0);
        chk("issue_valid_held", {31'h0, req_valid}, 32'h1);
        req_ready = 1'b1;
        tick(1);
        req_ready = 1'b0;
        chk("handshake_drop", {31'h0, req_valid}, 32'h0);
        press_key(3);
        chk("reissue_valid", {31'h0, req_valid}, 32'h1);
        chk("reissue_a", port_a, 32'h5);
        chk("reissue_b", port_b, 32'h3);
        chk("reissue_op", {28'h0, aluop}, 32'h2);
        req_ready = 1'b1;
        tick(1);
        req_ready = 1'b0;
        chk("reissue_drop", {31'h0, req_valid}, 32'h0);

        // 4: execute with incomplete operands
        do_reset(2);
        sw = 18'h00005;
        tick(3);
        press_key(0);
        key_n[3] = 1'b0;
        tick(6);
        chk("err_before", {31'h0, err}, 32'h0);
        tick(1);
        chk("err_pulse", {31'h0, err}, 32'h1);
        tick(1);
        chk("err_after", {31'h0, err}, 32'h0);
        chk("err_no_valid", {31'h0, req_valid}, 32'h0);
        key_n[3] = 1'b1;
        tick(8);

        // 5: operand extension
        sw = 18'h08001;
        tick(3);
        press_key(0);
        chk("ext_port_a", port_a, EXT_8001);

        // 6: reset while a request is pending
        press_key(1);
        press_key(2);
        press_key(3);
        chk("pre_rst_valid", {31'h0, req_valid}, 32'h1);
        do_reset(1);
        chk("midrst_valid", {31'h0, req_valid}, 32'h0);
        chk("midrst_loaded", {29'h0, loaded}, 32'h0);
        chk("midrst_port_a", port_a, 32'h0);
        tick(8);
        chk("post_rst_valid", {31'h0, req_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
